// File: rtl/mem_access_ctrl_pkg.sv
// Shared LC-3b types for the memory-stage sequencer: word/opcode/control word,
// sequencer states and byte-enable constants.
package mem_access_ctrl_pkg;

   localparam int LC3B_WORD_W = 16;

   typedef logic [LC3B_WORD_W-1:0] lc3b_word;

   typedef enum logic [3:0] {
      OP_BR   = 4'b0000,
      OP_ADD  = 4'b0001,
      OP_LDB  = 4'b0010,
      OP_STB  = 4'b0011,
      OP_JSR  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_LDR  = 4'b0110,
      OP_STR  = 4'b0111,
      OP_RTI  = 4'b1000,
      OP_NOT  = 4'b1001,
      OP_LDI  = 4'b1010,
      OP_STI  = 4'b1011,
      OP_JMP  = 4'b1100,
      OP_SHF  = 4'b1101,
      OP_LEA  = 4'b1110,
      OP_TRAP = 4'b1111
   } lc3b_opcode;

   typedef struct packed {
      lc3b_opcode opcode;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] marmux_sel;
      logic       wordinmux_sel;
   } lc3b_control_word;

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} mem_state_t;

   localparam logic [1:0] BE_WORD     = 2'b11;
   localparam logic [1:0] BE_LO       = 2'b01;
   localparam logic [1:0] BE_HI       = 2'b10;
   localparam logic [1:0] MARMUX_TRAP = 2'b01;

   function automatic lc3b_word word_align(input lc3b_word a);
      return {a[LC3B_WORD_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for the data-memory port: byte enables, store-byte
// replication and zero-extended load-byte extraction from the address LSB.
module byte_lane_unit
   import mem_access_ctrl_pkg::*;
(
   input  logic       addr_lsb,
   input  logic       is_byte,
   input  lc3b_word   store_data,
   input  lc3b_word   rdata,
   output logic [1:0] be,
   output lc3b_word   wdata,
   output lc3b_word   load_data
);

   always_comb begin
      be        = BE_WORD;
      wdata     = store_data;
      load_data = rdata;
      if (is_byte) begin
         be        = addr_lsb ? BE_HI : BE_LO;
         wdata     = {store_data[7:0], store_data[7:0]};
         load_data = {8'h00, (addr_lsb ? rdata[15:8] : rdata[7:0])};
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: runs the data-memory part of one decoded op, including
// the LDI/STI pointer indirection and TRAP vector fetch, and returns the result.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  lc3b_control_word  ctrl,
   input  logic [WORD_W-1:0] addr,
   input  logic [7:0]        trapvect8,
   input  logic [WORD_W-1:0] store_data,
   input  logic              flush,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [WORD_W-1:0] dmem_address,
   output logic [WORD_W-1:0] dmem_wdata,
   output logic [1:0]        dmem_byte_enable,
   input  logic [WORD_W-1:0] dmem_rdata,
   input  logic              dmem_resp,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data
);

   mem_state_t state_q, state_d;
   logic       in_ready_q, in_ready_d;
   logic       dmem_read_q, dmem_read_d, dmem_write_q, dmem_write_d;
   logic       out_valid_q, out_valid_d, squash_q, squash_d;
   logic [1:0] be_q, be_d;
   lc3b_word   dmem_address_q, dmem_address_d, dmem_wdata_q, dmem_wdata_d;
   lc3b_word   out_data_q, out_data_d;
   lc3b_opcode opcode_q, opcode_d;
   logic       byte_q, byte_d, addr0_q, addr0_d;
   lc3b_word   sdata_q, sdata_d;

   logic       accept, is_byte_in, is_store_in, kill;
   logic       bl_lsb, bl_byte;
   logic [1:0] bl_be;
   lc3b_word   bl_wdata, bl_load;

   assign accept      = in_valid & in_ready_q;
   assign is_byte_in  = ctrl.wordinmux_sel | (ctrl.opcode == OP_STB);
   assign is_store_in = (ctrl.opcode == OP_STR) | (ctrl.opcode == OP_STB);
   assign kill        = squash_q | flush;

   // Lane unit sees live inputs while accepting, the latched op afterwards.
   assign bl_lsb  = (state_q == IDLE) ? addr[0] : addr0_q;
   assign bl_byte = (state_q == IDLE) ? is_byte_in : byte_q;

   byte_lane_unit u_lanes (
      .addr_lsb   (bl_lsb),
      .is_byte    (bl_byte),
      .store_data (store_data),
      .rdata      (dmem_rdata),
      .be         (bl_be),
      .wdata      (bl_wdata),
      .load_data  (bl_load)
   );

   always_comb begin
      state_d        = state_q;
      dmem_read_d    = dmem_read_q;
      dmem_write_d   = dmem_write_q;
      dmem_address_d = dmem_address_q;
      dmem_wdata_d   = dmem_wdata_q;
      be_d           = be_q;
      out_valid_d    = 1'b0;
      out_data_d     = out_data_q;
      squash_d       = squash_q;
      opcode_d       = opcode_q;
      byte_d         = byte_q;
      addr0_d        = addr0_q;
      sdata_d        = sdata_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               opcode_d = ctrl.opcode;
               byte_d   = is_byte_in;
               addr0_d  = addr[0];
               sdata_d  = store_data;
               if (flush) begin
                  state_d = IDLE;
               end else if (ctrl.mem_read | ctrl.mem_write) begin
                  state_d      = ACC1;
                  dmem_read_d  = ~is_store_in;
                  dmem_write_d = is_store_in;
                  be_d         = bl_be;
                  dmem_wdata_d = bl_wdata;
                  if (ctrl.marmux_sel == MARMUX_TRAP)
                     dmem_address_d = {7'b0, trapvect8, 1'b0};
                  else if (is_byte_in)
                     dmem_address_d = addr;
                  else
                     dmem_address_d = word_align(addr);
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = '0;
               end
            end
         end
         ACC1: begin
            if (dmem_resp) begin
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               if (kill) begin
                  state_d    = DONE;
                  out_data_d = '0;
               end else if (opcode_q == OP_LDI || opcode_q == OP_STI) begin
                  state_d        = ACC2;
                  dmem_address_d = word_align(dmem_rdata);
                  dmem_read_d    = (opcode_q == OP_LDI);
                  dmem_write_d   = (opcode_q == OP_STI);
                  be_d           = BE_WORD;
                  dmem_wdata_d   = sdata_q;
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = dmem_write_q ? '0 : bl_load;
               end
            end else if (flush) begin
               squash_d = 1'b1;
            end
         end
         ACC2: begin
            if (dmem_resp) begin
               state_d      = DONE;
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               out_valid_d  = ~kill;
               out_data_d   = (opcode_q == OP_LDI && !kill) ? dmem_rdata : '0;
            end else if (flush) begin
               squash_d = 1'b1;
            end
         end
         DONE: begin
            state_d  = IDLE;
            squash_d = 1'b0;
         end
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         in_ready_q     <= 1'b0;
         dmem_read_q    <= 1'b0;
         dmem_write_q   <= 1'b0;
         dmem_address_q <= '0;
         dmem_wdata_q   <= '0;
         be_q           <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         squash_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         dmem_read_q    <= dmem_read_d;
         dmem_write_q   <= dmem_write_d;
         dmem_address_q <= dmem_address_d;
         dmem_wdata_q   <= dmem_wdata_d;
         be_q           <= be_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         squash_q       <= squash_d;
      end
   end

   always_ff @(posedge clk) begin
      opcode_q <= opcode_d;
      byte_q   <= byte_d;
      addr0_q  <= addr0_d;
      sdata_q  <= sdata_d;
   end

   assign in_ready         = in_ready_q;
   assign dmem_read        = dmem_read_q;
   assign dmem_write       = dmem_write_q;
   assign dmem_address     = dmem_address_q;
   assign dmem_wdata       = dmem_wdata_q;
   assign dmem_byte_enable = be_q;
   assign out_valid        = out_valid_q;
   assign out_data         = out_data_q;

endmodule
